// File: rtl/pcg_range_sampler_if.sv
`default_nettype none
// ============================================================================
// Module   : pcg_range_sampler_if
// Brief    : Request, generator and response signals of pcg_range_sampler.
// Revision : 1.0 - initial release
// ============================================================================
interface pcg_range_sampler_if #(
   parameter int W = 32
);
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] bound;
   logic         rand_req;
   logic [W-1:0] rand_in;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_err;
   logic         rsp_biased;
   logic [7:0]   tries;

   modport slave (
      input  req_valid, bound, rand_in, rsp_ready,
      output req_ready, rand_req, rsp_valid, rsp_data, rsp_err, rsp_biased, tries
   );

   modport master (
      output req_valid, bound, rand_in, rsp_ready,
      input  req_ready, rand_req, rsp_valid, rsp_data, rsp_err, rsp_biased, tries
   );
endinterface
`default_nettype wire

// File: rtl/pcg_range_sampler.sv
`default_nettype none
// ============================================================================
// Module   : pcg_range_sampler
// Brief    : Unbiased [0, bound) integers from a 32-bit PCG stream using
//            Lemire multiply-and-reject with a sequential threshold divider.
// Revision : 1.0 - initial release
// ============================================================================
module pcg_range_sampler #(
   parameter int W         = 32,
   parameter int MAX_TRIES = 16
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   pcg_range_sampler_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_THRESH = 3'd1,
      S_DRAW   = 3'd2,
      S_WAIT   = 3'd3,
      S_CHECK  = 3'd4,
      S_RESP   = 3'd5
   } state_t;

   localparam int           C_CW        = (W > 1) ? $clog2(W) : 1;
   localparam logic [C_CW-1:0] C_LAST   = C_CW'(W - 1);
   localparam logic [7:0]   C_MAX_TRIES = 8'(MAX_TRIES);

   state_t          state, next_state;
   logic [W-1:0]    r_bound;
   logic [W-1:0]    r_thr;
   logic [W-1:0]    r_x;
   logic [W:0]      r_rem;
   logic [W-1:0]    r_dvd;
   logic [C_CW-1:0] r_cnt;
   logic [7:0]      r_tries;
   logic [W-1:0]    r_data;
   logic            r_err;
   logic            r_biased;

   logic [W-1:0]    w_neg_bound;
   logic            w_rem_ge;
   logic [W-1:0]    w_rem_red;
   logic [2*W-1:0]  w_prod;
   logic [W-1:0]    w_lo;
   logic [W-1:0]    w_hi;
   logic            w_lo_ok;
   logic            w_accept;

   assign w_neg_bound = W'(0) - bus.bound;

   // Partial remainder already holds the next dividend bit; reduce it by one restoring step.
   assign w_rem_ge  = (r_rem >= {1'b0, r_bound});
   assign w_rem_red = w_rem_ge ? W'(r_rem - {1'b0, r_bound}) : r_rem[W-1:0];

   assign w_prod   = {{W{1'b0}}, r_x} * {{W{1'b0}}, r_bound};
   assign w_lo     = w_prod[W-1:0];
   assign w_hi     = w_prod[2*W-1:W];
   assign w_lo_ok  = (w_lo >= r_thr);
   assign w_accept = w_lo_ok || (r_tries >= C_MAX_TRIES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (bus.req_valid) next_state = (bus.bound == '0) ? S_RESP : S_THRESH;
         S_THRESH: if (r_cnt == C_LAST) next_state = S_DRAW;
         S_DRAW:   next_state = S_WAIT;
         S_WAIT:   next_state = S_CHECK;
         S_CHECK:  next_state = w_accept ? S_RESP : S_DRAW;
         S_RESP:   if (bus.rsp_ready) next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bound  <= '0;
         r_thr    <= '0;
         r_x      <= '0;
         r_rem    <= '0;
         r_dvd    <= '0;
         r_cnt    <= '0;
         r_tries  <= '0;
         r_data   <= '0;
         r_err    <= 1'b0;
         r_biased <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_bound <= bus.bound;
                  r_tries <= '0;
                  r_cnt   <= '0;
                  r_rem   <= {{W{1'b0}}, w_neg_bound[W-1]};
                  r_dvd   <= {w_neg_bound[W-2:0], 1'b0};
                  if (bus.bound == '0) begin
                     r_data   <= '0;
                     r_err    <= 1'b1;
                     r_biased <= 1'b0;
                  end
               end
            end
            S_THRESH: begin
               r_rem <= {w_rem_red, r_dvd[W-1]};
               r_dvd <= {r_dvd[W-2:0], 1'b0};
               r_cnt <= r_cnt + C_CW'(1);
               if (r_cnt == C_LAST) r_thr <= w_rem_red;
            end
            S_DRAW: begin
               if (r_tries != 8'hFF) r_tries <= r_tries + 8'd1;
            end
            S_WAIT: begin
               r_x <= bus.rand_in;
            end
            S_CHECK: begin
               if (w_accept) begin
                  r_data   <= w_hi;
                  r_err    <= 1'b0;
                  r_biased <= ~w_lo_ok;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready  = (state == S_IDLE) && rst_n;
   assign bus.rand_req   = (state == S_DRAW);
   assign bus.rsp_valid  = (state == S_RESP);
   assign bus.rsp_data   = r_data;
   assign bus.rsp_err    = r_err;
   assign bus.rsp_biased = r_biased;
   assign bus.tries      = r_tries;
endmodule
`default_nettype wire

// File: tb/tb_pcg_range_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcg_range_sampler
// Brief    : Directed self-checking bench for pcg_range_sampler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcg_range_sampler;
   localparam int W  = 32;
   localparam int MT = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   pcg_range_sampler_if #(.W(W)) bus ();

   pcg_range_sampler #(.W(W), .MAX_TRIES(MT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Generator stand-in: a new word appears after every rand_req pulse.
   logic [W-1:0] rand_seq[$];
   logic [W-1:0] rand_fill = '0;
   int   ncyc = 0, pulses = 0, last_pulse = -100, pulse_gap = 0;
   bit   prev_req = 1'b0, back_to_back = 1'b0;

   always @(negedge clk) begin
      ncyc     <= ncyc + 1;
      prev_req <= bus.rand_req;
      if (bus.rand_req) begin
         pulses     <= pulses + 1;
         last_pulse <= ncyc;
         pulse_gap  <= ncyc - last_pulse;
         if (prev_req) back_to_back <= 1'b1;
         if (rand_seq.size() > 0) bus.rand_in <= rand_seq.pop_front();
         else                     bus.rand_in <= rand_fill;
      end
   end

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_request(input logic [W-1:0] b, output int lat);
      @(negedge clk);
      bus.bound     = b;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.bound     = '0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.rsp_valid && lat < 200);
   endtask

   task automatic do_test(input string tag, input logic [W-1:0] b,
                          input logic [W-1:0] e_data, input bit e_err, input bit e_biased,
                          input int e_tries, input int e_lat, input int e_pulses, input int hold);
      int lat, p0;
      p0 = pulses;
      run_request(b, lat);
      check_value({tag, ".latency"}, 64'(lat), 64'(e_lat));
      check_value({tag, ".data"},    64'(bus.rsp_data), 64'(e_data));
      check_value({tag, ".err"},     64'(bus.rsp_err), 64'(e_err));
      check_value({tag, ".biased"},  64'(bus.rsp_biased), 64'(e_biased));
      check_value({tag, ".tries"},   64'(bus.tries), 64'(e_tries));
      check_value({tag, ".pulses"},  64'(pulses - p0), 64'(e_pulses));
      check_value({tag, ".no_b2b"},  64'(back_to_back), 64'(0));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_value({tag, ".hold_valid"}, 64'(bus.rsp_valid), 64'(1));
         check_value({tag, ".hold_data"},  64'(bus.rsp_data), 64'(e_data));
         check_value({tag, ".hold_err"},   64'(bus.rsp_err), 64'(e_err));
         check_value({tag, ".hold_ready"}, 64'(bus.req_ready), 64'(0));
      end
      @(negedge clk);
      check_value({tag, ".busy_ready"}, 64'(bus.req_ready), 64'(0));
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      check_value({tag, ".valid_drop"}, 64'(bus.rsp_valid), 64'(0));
      check_value({tag, ".ready_back"}, 64'(bus.req_ready), 64'(1));
   endtask

   initial begin
      int p0;
      bit saw_valid;
      int lat;
      bus.req_valid = 1'b0;
      bus.bound     = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_value("rst.valid",  64'(bus.rsp_valid), 64'(0));
      check_value("rst.data",   64'(bus.rsp_data), 64'(0));
      check_value("rst.err",    64'(bus.rsp_err), 64'(0));
      check_value("rst.biased", 64'(bus.rsp_biased), 64'(0));
      check_value("rst.tries",  64'(bus.tries), 64'(0));
      check_value("rst.rreq",   64'(bus.rand_req), 64'(0));
      rst_n = 1'b1;
      #1;
      check_value("rst.ready",  64'(bus.req_ready), 64'(1));

      rand_seq.push_back(32'hFFFF_FFFF);
      do_test("b6_one", 32'd6, 32'd5, 1'b0, 1'b0, 1, 36, 1, 0);

      do_test("b0", 32'd0, 32'd0, 1'b1, 1'b0, 0, 1, 0, 5);

      rand_seq.push_back(32'h0000_0000);
      rand_seq.push_back(32'h8000_0001);
      do_test("b6_rej", 32'd6, 32'd3, 1'b0, 1'b0, 2, 39, 2, 0);
      check_value("b6_rej.gap", 64'(pulse_gap), 64'(3));

      rand_seq.push_back(32'hC000_0000);
      do_test("b2p31", 32'h8000_0000, 32'h6000_0000, 1'b0, 1'b0, 1, 36, 1, 0);

      rand_seq.push_back(32'h1234_5678);
      do_test("b1", 32'd1, 32'd0, 1'b0, 1'b0, 1, 36, 1, 0);

      rand_seq.push_back(32'h8000_0000);
      do_test("b7", 32'd7, 32'd3, 1'b0, 1'b0, 1, 36, 1, 0);

      rand_fill = '0;
      do_test("exhaust", 32'd6, 32'd0, 1'b0, 1'b1, MT, 1 + W + 3 * MT, MT, 0);

      // Abandon a request partway through the threshold division.
      p0 = pulses;
      @(negedge clk);
      bus.bound     = 32'd6;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_value("midrst.valid",  64'(bus.rsp_valid), 64'(0));
      check_value("midrst.biased", 64'(bus.rsp_biased), 64'(0));
      check_value("midrst.tries",  64'(bus.tries), 64'(0));
      check_value("midrst.rreq",   64'(bus.rand_req), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_value("midrst.ready",  64'(bus.req_ready), 64'(1));
      saw_valid = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (bus.rsp_valid) saw_valid = 1'b1;
      end
      check_value("midrst.no_rsp",    64'(saw_valid), 64'(0));
      check_value("midrst.no_pulse",  64'(pulses - p0), 64'(0));

      rand_seq.push_back(32'hFFFF_FFFF);
      do_test("after_rst", 32'd6, 32'd5, 1'b0, 1'b0, 1, 36, 1, 0);

      lat = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + lat);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
